serial_subtract_ctrl: RTL and testbench

Bit-serial sequencer for the single-bit gate-level full-subtractor cell. It latches two WIDTH-bit operands on a start request and presents one bit pair per clock, LSB first, to an external full-subtractor cell. It carries the borrow between cycles in a flip-flop and collects the difference bits into a result register. The cell stays purely combinational and fault-simulatable; this block adds only the sequencing around it.

---
 rtl/serial_subtract_ctrl.sv | 122 ++++++++++++
 tb/tb_serial_subtract_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtract_ctrl.sv
// serial_subtract_ctrl: bit-serial sequencer around an external single-bit
// full-subtractor cell. The operands are latched on start and fed to the cell
// one bit pair per clock, LSB first. The borrow travels between cycles in a
// flip-flop, and the difference bits are shifted into a result register.
//
// Handshake: start is a level request. It is sampled only in IDLE; while busy
// it is ignored and a/b are not resampled. done is a one-cycle pulse in DONE.
// diff/borrow_out are valid from that cycle until the first RUN edge of the
// next operation. start may be held high for back-to-back operation, which
// gives one operation every WIDTH+2 cycles.
module serial_subtract_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             fs_a,
  output logic             fs_b,
  output logic             fs_bin,
  input  logic             fs_d,
  input  logic             fs_bout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Hierarchically visible FSM state, available for checkers to bind to.
  state_e state_q, state_d;

  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] d_sh_q, d_sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             brw_q, brw_d;
  logic             borrow_q, borrow_d;

  // State and datapath registers; the synchronous reset takes priority over start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      d_sh_q   <= '0;
      cnt_q    <= '0;
      brw_q    <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      d_sh_q   <= d_sh_d;
      cnt_q    <= cnt_d;
      brw_q    <= brw_d;
      borrow_q <= borrow_d;
    end
  end

  // Next-state logic and cell drive. fs_* are nonzero only in RUN, so the cell
  // sees a quiet input while the block is idle or finishing.
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    d_sh_d   = d_sh_q;
    cnt_d    = cnt_q;
    brw_d    = brw_q;
    borrow_d = borrow_q;
    fs_a     = 1'b0;
    fs_b     = 1'b0;
    fs_bin   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          brw_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        fs_a   = a_sh_q[0];
        fs_b   = b_sh_q[0];
        fs_bin = brw_q;
        d_sh_d = {fs_d, d_sh_q[WIDTH-1:1]};
        brw_d  = fs_bout;
        a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          borrow_d = fs_bout;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign diff       = d_sh_q;
  assign borrow_out = borrow_q;

endmodule

// File: tb/tb_serial_subtract_ctrl.sv
// Directed and randomized bench for serial_subtract_ctrl (WIDTH = 8) with a
// behavioural full-subtractor cell closing the loop on fs_*.
module tb_serial_subtract_ctrl;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         fs_a, fs_b, fs_bin, fs_d, fs_bout;
  logic         busy, done, borrow_out;
  logic [W-1:0] diff;

  int total = 0;
  int bad   = 0;
  logic [W:0] exp_q[$];

  // Full-subtractor cell: d = a^b^bin, bout = ~a&b | ~(a^b)&bin.
  assign fs_d    = fs_a ^ fs_b ^ fs_bin;
  assign fs_bout = (~fs_a & fs_b) | (~(fs_a ^ fs_b) & fs_bin);

  serial_subtract_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .fs_a(fs_a), .fs_b(fs_b), .fs_bin(fs_bin), .fs_d(fs_d), .fs_bout(fs_bout),
    .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  // Request one operation; returns at the falling edge of RUN cycle 1.
  task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv);
    a = av;
    b = bv;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Advance until done is seen or the budget runs out.
  task automatic wait_done(input int limit, output int n, output bit seen);
    n = 0;
    seen = done;
    while (!seen && n < limit) begin
      tick();
      n++;
      seen = done;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int n;
    bit seen;
    rst_n = 1'b0;
    start = 1'b0;
    tick();
    tick();
    total++;
    if ({busy, done, diff, borrow_out, fs_a, fs_b, fs_bin} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got busy=%b done=%b diff=%h bo=%b fs=%b%b%b, want all 0",
               busy, done, diff, borrow_out, fs_a, fs_b, fs_bin);
    end
    // Reset wins over start on the same edge.
    a = 8'h09;
    b = 8'h04;
    start = 1'b1;
    tick();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_priority: busy=%b want 0", busy);
    end
    // Start held through reset release is taken at the first free edge.
    rst_n = 1'b1;
    tick();
    start = 1'b0;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL start_after_reset: busy=%b want 1", busy);
    end
    wait_done(12, n, seen);
    total++;
    if (!seen || {borrow_out, diff} !== 9'h005) begin
      bad++;
      $display("FAIL start_after_reset_result: seen=%b got %b/%h want 0/05", seen, borrow_out, diff);
    end
    tick();
  endtask

  task automatic test_basic();
    int busy_cnt = 0;
    int done_cnt = 0;
    int done_at = 0;
    launch(8'h05, 8'h03);
    for (int i = 1; i <= 11; i++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_at == 0) done_at = i;
        total++;
        if (diff !== 8'h02 || borrow_out !== 1'b0) begin
          bad++;
          $display("FAIL basic_result: got %b/%h want 0/02", borrow_out, diff);
        end
      end
      tick();
    end
    total++;
    if (busy_cnt != 9) begin
      bad++;
      $display("FAIL basic_busy_len: got %0d want 9", busy_cnt);
    end
    total++;
    if (done_at != 9 || done_cnt != 1) begin
      bad++;
      $display("FAIL basic_done_timing: at=%0d count=%0d want at=9 count=1", done_at, done_cnt);
    end
  endtask

  // Per-cycle check of the cell drive; the borrow into bit k is 1 exactly
  // when the low k bits of a are below the low k bits of b.
  task automatic test_borrow_seq();
    logic [W-1:0] av = 8'h03;
    logic [W-1:0] bv = 8'h05;
    logic [W:0] mask, lo_a, lo_b;
    logic exp_bin;
    launch(av, bv);
    for (int k = 0; k < W; k++) begin
      mask = (9'd1 << k) - 9'd1;
      lo_a = {1'b0, av} & mask;
      lo_b = {1'b0, bv} & mask;
      exp_bin = (lo_a < lo_b);
      total++;
      if (fs_bin !== exp_bin || fs_a !== av[k] || fs_b !== bv[k]) begin
        bad++;
        $display("FAIL borrow_seq bit %0d: got a=%b b=%b bin=%b want a=%b b=%b bin=%b",
                 k, fs_a, fs_b, fs_bin, av[k], bv[k], exp_bin);
      end
      tick();
    end
    total++;
    if (done !== 1'b1 || diff !== 8'hFE || borrow_out !== 1'b1) begin
      bad++;
      $display("FAIL borrow_seq_result: done=%b got %b/%h want 1/FE", done, borrow_out, diff);
    end
    tick();
  endtask

  task automatic test_zero();
    int n;
    bit seen;
    launch(8'h00, 8'h00);
    wait_done(12, n, seen);
    total++;
    if (!seen || {borrow_out, diff} !== 9'h000) begin
      bad++;
      $display("FAIL zero_zero: seen=%b got %b/%h want 0/00", seen, borrow_out, diff);
    end
    tick();
    launch(8'h00, 8'hFF);
    wait_done(12, n, seen);
    total++;
    if (!seen || {borrow_out, diff} !== 9'h101) begin
      bad++;
      $display("FAIL zero_minus_ff: seen=%b got %b/%h want 1/01", seen, borrow_out, diff);
    end
    tick();
  endtask

  task automatic test_ignore_start();
    int n;
    bit seen;
    launch(8'h80, 8'h01);
    tick();
    tick();
    a = 8'hFF;
    b = 8'hFF;
    start = 1'b1;
    wait_done(12, n, seen);
    total++;
    if (!seen || n != 6 || {borrow_out, diff} !== 9'h07F) begin
      bad++;
      $display("FAIL ignore_start: seen=%b n=%0d got %b/%h want n=6 0/7F", seen, n, borrow_out, diff);
    end
    tick();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL ignore_idle_gap: busy=%b want 0", busy);
    end
    tick();
    start = 1'b0;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL ignore_next_accept: busy=%b want 1", busy);
    end
    wait_done(12, n, seen);
    total++;
    if (!seen || n != 8 || {borrow_out, diff} !== 9'h000) begin
      bad++;
      $display("FAIL ignore_second_op: seen=%b n=%0d got %b/%h want n=8 0/00", seen, n, borrow_out, diff);
    end
    tick();
  endtask

  task automatic test_reset_mid_run();
    int n;
    bit seen;
    int done_cnt = 0;
    launch(8'h10, 8'h20);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    total++;
    if ({busy, done, diff, borrow_out, fs_a, fs_b, fs_bin} !== '0) begin
      bad++;
      $display("FAIL midrun_reset: got busy=%b done=%b diff=%h bo=%b fs=%b%b%b, want all 0",
               busy, done, diff, borrow_out, fs_a, fs_b, fs_bin);
    end
    for (int i = 0; i < 12; i++) begin
      if (done || busy) done_cnt++;
      tick();
    end
    total++;
    if (done_cnt != 0) begin
      bad++;
      $display("FAIL midrun_no_done: active cycles=%0d want 0", done_cnt);
    end
    launch(8'h20, 8'h10);
    wait_done(12, n, seen);
    total++;
    if (!seen || {borrow_out, diff} !== 9'h010) begin
      bad++;
      $display("FAIL midrun_fresh_op: seen=%b got %b/%h want 0/10", seen, borrow_out, diff);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int n;
    bit seen;
    logic [W:0] exp;
    a = W'($urandom_range(0, 255));
    b = W'($urandom_range(0, 255));
    exp_q.push_back({1'b0, a} - {1'b0, b});
    start = 1'b1;
    for (int op = 0; op < 1000; op++) begin
      tick();
      wait_done(14, n, seen);
      if (!seen) begin
        total++;
        bad++;
        $display("FAIL b2b_timeout: op %0d produced no done", op);
        break;
      end
      exp = exp_q.pop_front();
      total++;
      if ({borrow_out, diff} !== exp) begin
        bad++;
        $display("FAIL b2b_result op %0d: got %b/%h want %b/%h", op, borrow_out, diff, exp[W], exp[W-1:0]);
      end
      if (op > 0) begin
        total++;
        if (n + 1 != 10) begin
          bad++;
          $display("FAIL b2b_spacing op %0d: got %0d want 10", op, n + 1);
        end
      end
      if (op < 999) begin
        a = W'($urandom_range(0, 255));
        b = W'($urandom_range(0, 255));
        exp_q.push_back({1'b0, a} - {1'b0, b});
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    tick();
    tick();
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_basic();
    test_borrow_seq();
    test_zero();
    test_ignore_start();
    test_reset_mid_run();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
